// File: rtl/multi_vc_flits_buffer.sv
// Multi-VC receive-side flit buffer: assembles one packet per virtual channel,
// round-robin arbitrates complete packets and presents them with a req/grant handshake.
module multi_vc_flits_buffer #(
  parameter int unsigned FLIT_WIDTH        = 64,
  parameter int unsigned MAX_PACKET_LENGTH = 8,
  parameter int unsigned N_VC              = 2,
  parameter int unsigned N_BITS_POINTER    = $clog2(MAX_PACKET_LENGTH),
  localparam int unsigned VC_BITS          = (N_VC > 1) ? $clog2(N_VC) : 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [FLIT_WIDTH-1:0]                   in_link_i,
  input  logic                                    is_valid_i,
  input  logic [VC_BITS-1:0]                      in_vc_i,
  output logic [N_VC-1:0]                         credit_signal_o,
  output logic [N_VC-1:0]                         free_signal_o,
  output logic                                    r_pkt_to_msg_o,
  input  logic                                    g_pkt_to_msg_i,
  output logic [VC_BITS-1:0]                      out_vc_o,
  output logic [MAX_PACKET_LENGTH*FLIT_WIDTH-1:0] out_link_o,
  output logic [MAX_PACKET_LENGTH-1:0]            out_sel_o,
  output logic                                    error_o
);

  localparam logic [1:0] FtHead     = 2'b00;
  localparam logic [1:0] FtBody     = 2'b01;
  localparam logic [1:0] FtTail     = 2'b10;
  localparam logic [1:0] FtHeadTail = 2'b11;

  localparam logic [N_BITS_POINTER-1:0] LastSlot = N_BITS_POINTER'(MAX_PACKET_LENGTH - 1);

  typedef enum logic [1:0] {StIdle, StFilling, StFull} vc_state_e;

  vc_state_e                    r_state   [N_VC];
  vc_state_e                    w_state_d [N_VC];
  logic [N_BITS_POINTER-1:0]    r_ptr     [N_VC];
  logic [N_BITS_POINTER-1:0]    w_ptr_d   [N_VC];
  logic [MAX_PACKET_LENGTH-1:0] r_mask    [N_VC];
  logic [MAX_PACKET_LENGTH-1:0] w_mask_d  [N_VC];
  logic [FLIT_WIDTH-1:0]        r_data    [N_VC][MAX_PACKET_LENGTH];

  logic [N_VC-1:0]              w_wr_en;
  logic [N_BITS_POINTER-1:0]    w_wr_slot [N_VC];
  logic                         w_drop;
  logic [1:0]                   w_type;
  int unsigned                  w_vc_int;

  logic [N_VC-1:0]              w_full;
  logic                         w_req;
  logic                         w_found;
  logic [VC_BITS-1:0]           w_sel_rr;
  logic [VC_BITS-1:0]           w_sel;
  logic                         w_grant;
  logic [N_VC-1:0]              w_credit_d;

  logic [VC_BITS-1:0]           r_rr;
  logic                         r_lock;
  logic [VC_BITS-1:0]           r_sel;
  logic [N_VC-1:0]              r_credit;
  logic                         r_err;

  assign w_type   = in_link_i[1:0];
  assign w_vc_int = 32'(in_vc_i);
  assign w_grant  = g_pkt_to_msg_i & w_req;

  // Per-VC next state: accept or drop the incoming flit, then apply the grant release.
  always_comb begin
    w_drop = 1'b0;
    for (int unsigned v = 0; v < N_VC; v++) begin
      w_state_d[v] = r_state[v];
      w_ptr_d[v]   = r_ptr[v];
      w_mask_d[v]  = r_mask[v];
      w_wr_en[v]   = 1'b0;
      w_wr_slot[v] = '0;
    end
    if (is_valid_i) begin
      if (w_vc_int >= N_VC) begin
        w_drop = 1'b1;
      end
      for (int unsigned v = 0; v < N_VC; v++) begin
        if (w_vc_int == v) begin
          unique case (r_state[v])
            StIdle: begin
              if (w_type == FtHead || w_type == FtHeadTail) begin
                w_wr_en[v]     = 1'b1;
                w_mask_d[v]    = '0;
                w_mask_d[v][0] = 1'b1;
                if (w_type == FtHead) begin
                  w_ptr_d[v]   = N_BITS_POINTER'(1);
                  w_state_d[v] = StFilling;
                end else begin
                  w_state_d[v] = StFull;
                end
              end else begin
                w_drop = 1'b1;
              end
            end
            StFilling: begin
              // The last slot is reserved for the tail, so a body there overflows.
              if ((w_type == FtBody && r_ptr[v] != LastSlot) || w_type == FtTail) begin
                w_wr_en[v]              = 1'b1;
                w_wr_slot[v]            = r_ptr[v];
                w_mask_d[v][r_ptr[v]]   = 1'b1;
                if (w_type == FtBody) begin
                  w_ptr_d[v] = r_ptr[v] + N_BITS_POINTER'(1);
                end else begin
                  w_state_d[v] = StFull;
                end
              end else begin
                w_drop = 1'b1;
              end
            end
            StFull: begin
              w_drop = 1'b1;
            end
            default: begin
              w_drop = 1'b1;
            end
          endcase
        end
      end
    end
    // The granted VC was FULL, so any flit to it this edge was already dropped above.
    if (w_grant) begin
      w_state_d[w_sel] = StIdle;
      w_ptr_d[w_sel]   = '0;
      w_mask_d[w_sel]  = '0;
    end
  end

  // Round-robin search for the first FULL VC at or after rr; locked selection wins.
  always_comb begin
    for (int unsigned v = 0; v < N_VC; v++) begin
      w_full[v]        = (r_state[v] == StFull);
      free_signal_o[v] = (r_state[v] == StIdle);
    end
    w_req    = |w_full;
    w_found  = 1'b0;
    w_sel_rr = '0;
    for (int unsigned i = 0; i < N_VC; i++) begin
      if (!w_found && w_full[(32'(r_rr) + i) % N_VC]) begin
        w_found  = 1'b1;
        w_sel_rr = VC_BITS'((32'(r_rr) + i) % N_VC);
      end
    end
    w_sel = r_lock ? r_sel : w_sel_rr;
    w_credit_d = '0;
    if (w_grant) begin
      w_credit_d[w_sel] = 1'b1;
    end
  end

  // Presented packet, gated to zero when no request is pending.
  always_comb begin
    r_pkt_to_msg_o = w_req;
    out_vc_o       = w_req ? w_sel : '0;
    out_sel_o      = w_req ? r_mask[w_sel] : '0;
    out_link_o     = '0;
    for (int unsigned i = 0; i < MAX_PACKET_LENGTH; i++) begin
      if (w_req && r_mask[w_sel][i]) begin
        out_link_o[i*FLIT_WIDTH +: FLIT_WIDTH] = r_data[w_sel][i];
      end
    end
  end

  // Control state: per-VC FSMs, arbitration pointer/lock and the pulse outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned v = 0; v < N_VC; v++) begin
        r_state[v] <= StIdle;
        r_ptr[v]   <= '0;
        r_mask[v]  <= '0;
      end
      r_rr     <= '0;
      r_lock   <= 1'b0;
      r_sel    <= '0;
      r_credit <= '0;
      r_err    <= 1'b0;
    end else begin
      for (int unsigned v = 0; v < N_VC; v++) begin
        r_state[v] <= w_state_d[v];
        r_ptr[v]   <= w_ptr_d[v];
        r_mask[v]  <= w_mask_d[v];
      end
      if (w_grant) begin
        r_rr <= VC_BITS'((32'(w_sel) + 32'd1) % N_VC);
      end
      r_lock   <= w_req & ~w_grant;
      r_sel    <= w_sel;
      r_credit <= w_credit_d;
      r_err    <= w_drop;
    end
  end

  // Flit storage; never reset because the mask hides stale contents.
  always_ff @(posedge clk) begin
    for (int unsigned v = 0; v < N_VC; v++) begin
      if (w_wr_en[v]) begin
        r_data[v][w_wr_slot[v]] <= in_link_i;
      end
    end
  end

  assign credit_signal_o = r_credit;
  assign error_o         = r_err;

endmodule

// File: tb/tb_multi_vc_flits_buffer.sv
// Directed bench for multi_vc_flits_buffer with a packet scoreboard.
module tb_multi_vc_flits_buffer;

  localparam int FW = 64;
  localparam int ML = 8;
  localparam int NV = 2;

  typedef struct {
    logic [0:0]     vc;
    logic [ML-1:0]  sel;
    logic [511:0]   link;
  } pkt_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [FW-1:0]     in_link_i = '0;
  logic              is_valid_i = 1'b0;
  logic [0:0]        in_vc_i = '0;
  logic [NV-1:0]     credit_signal_o;
  logic [NV-1:0]     free_signal_o;
  logic              r_pkt_to_msg_o;
  logic              g_pkt_to_msg_i = 1'b0;
  logic [0:0]        out_vc_o;
  logic [ML*FW-1:0]  out_link_o;
  logic [ML-1:0]     out_sel_o;
  logic              error_o;

  int n_assert = 0;
  int n_fail   = 0;

  pkt_t          exp_q [$];
  logic [511:0]  m_link [NV];
  logic [ML-1:0] m_sel  [NV];
  int            m_cnt  [NV];

  multi_vc_flits_buffer dut (
    .clk             (clk),
    .rst             (rst),
    .in_link_i       (in_link_i),
    .is_valid_i      (is_valid_i),
    .in_vc_i         (in_vc_i),
    .credit_signal_o (credit_signal_o),
    .free_signal_o   (free_signal_o),
    .r_pkt_to_msg_o  (r_pkt_to_msg_o),
    .g_pkt_to_msg_i  (g_pkt_to_msg_i),
    .out_vc_o        (out_vc_o),
    .out_link_o      (out_link_o),
    .out_sel_o       (out_sel_o),
    .error_o         (error_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int v = 0; v < NV; v++) begin
      m_link[v] = '0;
      m_sel[v]  = '0;
      m_cnt[v]  = 0;
    end
  endtask

  // Record an accepted flit; a tail or head_tail closes the packet into the scoreboard.
  task automatic model_accept(input int vc, input logic [FW-1:0] data);
    pkt_t p;
    m_link[vc][m_cnt[vc]*FW +: FW] = data;
    m_sel[vc][m_cnt[vc]] = 1'b1;
    m_cnt[vc]++;
    if (data[1]) begin
      p.vc   = 1'(vc);
      p.sel  = m_sel[vc];
      p.link = m_link[vc];
      exp_q.push_back(p);
      m_link[vc] = '0;
      m_sel[vc]  = '0;
      m_cnt[vc]  = 0;
    end
  endtask

  task automatic send(input int vc, input logic [FW-1:0] data, input bit exp_drop,
                      input string tag);
    in_link_i  = data;
    in_vc_i    = 1'(vc);
    is_valid_i = 1'b1;
    tick();
    is_valid_i = 1'b0;
    chk({tag, "_err"}, 512'(error_o), 512'(exp_drop));
    if (!exp_drop) model_accept(vc, data);
  endtask

  // Compare the presented packet with the scoreboard head, grant it, check release.
  task automatic grant(input bit with_flit, input int fvc, input logic [FW-1:0] fdata,
                       input bit fdrop, input string tag);
    pkt_t p;
    chk({tag, "_req"}, 512'(r_pkt_to_msg_o), 512'(1));
    if (exp_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s_sb: observed empty scoreboard, expected a queued packet", tag);
      return;
    end
    p = exp_q.pop_front();
    chk({tag, "_vc"}, 512'(out_vc_o), 512'(p.vc));
    chk({tag, "_sel"}, 512'(out_sel_o), 512'(p.sel));
    chk({tag, "_link"}, out_link_o, p.link);
    g_pkt_to_msg_i = 1'b1;
    if (with_flit) begin
      in_link_i  = fdata;
      in_vc_i    = 1'(fvc);
      is_valid_i = 1'b1;
    end
    tick();
    g_pkt_to_msg_i = 1'b0;
    is_valid_i     = 1'b0;
    if (with_flit) begin
      chk({tag, "_gflit_err"}, 512'(error_o), 512'(fdrop));
      if (!fdrop) model_accept(fvc, fdata);
    end
    chk({tag, "_credit"}, 512'(credit_signal_o), 512'(2'b01 << p.vc));
    chk({tag, "_free"}, 512'(free_signal_o[p.vc]), 512'(1));
    chk({tag, "_req_after"}, 512'(r_pkt_to_msg_o), 512'(exp_q.size() != 0));
    tick();
    chk({tag, "_credit_end"}, 512'(credit_signal_o), 512'(0));
  endtask

  initial begin
    model_clear();
    // Reset state
    tick();
    chk("rst_req", 512'(r_pkt_to_msg_o), 512'(0));
    chk("rst_free", 512'(free_signal_o), 512'(2'b11));
    chk("rst_sel", 512'(out_sel_o), 512'(0));
    chk("rst_credit", 512'(credit_signal_o), 512'(0));
    chk("rst_err", 512'(error_o), 512'(0));
    rst = 1'b1;
    tick();

    // Single head_tail on VC0
    send(0, 64'hFF3, 1'b0, "ht0");
    chk("ht0_free", 512'(free_signal_o), 512'(2'b10));
    grant(1'b0, 0, '0, 1'b0, "ht0_g");
    chk("ht0_free_after", 512'(free_signal_o), 512'(2'b11));

    // Grant with no request is ignored
    g_pkt_to_msg_i = 1'b1;
    tick();
    g_pkt_to_msg_i = 1'b0;
    chk("idle_g_credit", 512'(credit_signal_o), 512'(0));
    chk("idle_g_free", 512'(free_signal_o), 512'(2'b11));

    // Five-flit packet on VC1 with a valid gap
    send(1, 64'h00, 1'b0, "p1_h");
    send(1, 64'h11, 1'b0, "p1_b1");
    send(1, 64'h21, 1'b0, "p1_b2");
    tick();
    send(1, 64'h31, 1'b0, "p1_b3");
    send(1, 64'h72, 1'b0, "p1_t");
    grant(1'b0, 0, '0, 1'b0, "p1_g");

    // Selection stays locked on VC1 while VC0 completes behind it
    send(1, 64'hA3, 1'b0, "lk1");
    send(0, 64'hB7, 1'b0, "lk0");
    chk("lk_vc_held", 512'(out_vc_o), 512'(1));
    grant(1'b0, 0, '0, 1'b0, "lk_g1");
    grant(1'b0, 0, '0, 1'b0, "lk_g0");

    // Interleaved packets
    send(0, 64'h100, 1'b0, "il0_h");
    send(1, 64'h200, 1'b0, "il1_h");
    send(0, 64'h102, 1'b0, "il0_t");
    send(1, 64'h201, 1'b0, "il1_b");
    send(1, 64'h206, 1'b0, "il1_t");
    grant(1'b0, 0, '0, 1'b0, "il_g0");
    grant(1'b0, 0, '0, 1'b0, "il_g1");

    // Protocol violations
    send(0, 64'h5, 1'b1, "e_body_idle");
    chk("e_idle_free", 512'(free_signal_o), 512'(2'b11));
    send(0, 64'h300, 1'b0, "ov_h");
    send(0, 64'h301, 1'b0, "ov_b1");
    send(0, 64'h305, 1'b0, "ov_b2");
    send(0, 64'h309, 1'b0, "ov_b3");
    send(0, 64'h30C, 1'b1, "e_head_fill");
    send(0, 64'h311, 1'b0, "ov_b4");
    send(0, 64'h315, 1'b0, "ov_b5");
    send(0, 64'h319, 1'b0, "ov_b6");
    send(0, 64'h31D, 1'b1, "e_overflow");
    send(0, 64'h322, 1'b0, "ov_t");
    send(0, 64'h325, 1'b1, "e_full");
    tick();
    chk("e_pulse_once", 512'(error_o), 512'(0));
    // Grant VC0 while VC1 accepts a head_tail, then grant VC1 while it receives a flit
    grant(1'b1, 1, 64'hC3, 1'b0, "sim_g0");
    grant(1'b1, 1, 64'hD0, 1'b1, "sim_g1");

    // Asynchronous reset mid-packet
    send(0, 64'h400, 1'b0, "mr_h0");
    send(1, 64'h503, 1'b0, "mr_ht1");
    chk("mr_req_pre", 512'(r_pkt_to_msg_o), 512'(1));
    #3;
    rst = 1'b0;
    #1;
    chk("mr_req", 512'(r_pkt_to_msg_o), 512'(0));
    chk("mr_free", 512'(free_signal_o), 512'(2'b11));
    chk("mr_sel", 512'(out_sel_o), 512'(0));
    chk("mr_link", out_link_o, 512'(0));
    exp_q.delete();
    model_clear();
    tick();
    rst = 1'b1;
    tick();
    send(0, 64'hE3, 1'b0, "mr_after");
    grant(1'b0, 0, '0, 1'b0, "mr_g");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
